pregfile_wb_arbiter: RTL and testbench

Arbitrates writebacks from NUM_REQ functional-unit requesters onto the two write ports (port 0, port 1) of the 64-entry physical integer register file. Up to two grants per cycle: round-robin, with a starvation override and same-destination conflict deferral. Grants are registered, so write enables, addresses and data reach the register file one cycle after the handshake. The same registered outputs drive the issue-queue wakeup broadcast.

---
 rtl/pregfile_wb_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_pregfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pregfile_wb_arbiter.sv
// Writeback arbiter: picks up to two of NUM_REQ functional-unit results per cycle for the two preg-file write ports.
// Latency: grant (req_ready) is combinational; wrenN/waddrN/wdataN are registered and appear one cycle after the handshake.
// Backpressure: a requester holds valid/pdst/data until req_ready; denied requesters wait and are forced onto port 0 when starved.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester writeback handshake (ready only ever asserted with valid)
//   req_pdst/req_data     - packed per-requester destination preg and result, requester i at slice i
//   wren0/waddr0/wdata0   - registered write port 0 (also the wakeup broadcast)
//   wren1/waddr1/wdata1   - registered write port 1 (also the wakeup broadcast)
//   conflict_cnt          - saturating count of cycles with a same-pdst port-1 deferral

module pregfile_wb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PREG_W       = 6,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*PREG_W-1:0] req_pdst,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      wren0,
    output logic [PREG_W-1:0]         waddr0,
    output logic [DATA_W-1:0]         wdata0,
    output logic                      wren1,
    output logic [PREG_W-1:0]         waddr1,
    output logic [DATA_W-1:0]         wdata1,
    output logic [31:0]               conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Unpacked views of the per-requester buses
    // ------------------------------------------------------------------
    logic [PREG_W-1:0] pdst_a [NUM_REQ];
    logic [DATA_W-1:0] data_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign pdst_a[gi] = req_pdst[gi*PREG_W +: PREG_W];
        assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_q [NUM_REQ];
    logic [CNT_W-1:0]  wait_d [NUM_REQ];
    logic [31:0]       conflict_cnt_q, conflict_cnt_d;

    logic              wren0_q, wren0_d;
    logic [PREG_W-1:0] waddr0_q, waddr0_d;
    logic [DATA_W-1:0] wdata0_q, wdata0_d;
    logic              wren1_q, wren1_d;
    logic [PREG_W-1:0] waddr1_q, waddr1_d;
    logic [DATA_W-1:0] wdata1_q, wdata1_d;

    // ------------------------------------------------------------------
    // Arbitration results
    // ------------------------------------------------------------------
    logic              g0_vld;
    logic [IDX_W-1:0]  g0_idx;
    logic              g1_vld;
    logic [IDX_W-1:0]  g1_idx;
    logic              forced;
    logic              skip_any;
    logic [IDX_W-1:0]  scan_idx;
    logic [NUM_REQ-1:0] grant;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        if (x == IDX_W'(NUM_REQ - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = x + 1'b1;
        end
    endfunction

    always_comb begin
        g0_vld   = 1'b0;
        g0_idx   = '0;
        g1_vld   = 1'b0;
        g1_idx   = '0;
        forced   = 1'b0;
        skip_any = 1'b0;
        scan_idx = '0;

        // A starved requester owns port 0. Scanning downward lets the
        // lowest-index starved requester win.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (wait_q[i] == STARVE_MAX)) begin
                forced = 1'b1;
                g0_idx = IDX_W'(i);
            end
        end
        g0_vld = forced;

        // Circular scan from rr_ptr. Without a forced grant the first valid
        // requester takes port 0; port 1 goes to the next valid requester
        // that does not write the same nonzero preg as port 0. Once port 1
        // is filled the scan stops looking, so later matches are not skips.
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1_vld && (scan_idx != g0_idx)) begin
                    if ((pdst_a[scan_idx] != '0) &&
                        (pdst_a[scan_idx] == pdst_a[g0_idx])) begin
                        skip_any = 1'b1;
                    end else begin
                        g1_vld = 1'b1;
                        g1_idx = scan_idx;
                    end
                end
            end
        end

        // Nothing is granted while reset is held, so no handshake completes
        // and no state below sees a grant.
        if (reset) begin
            g0_vld   = 1'b0;
            g1_vld   = 1'b0;
            forced   = 1'b0;
            skip_any = 1'b0;
        end
    end

    always_comb begin
        grant = '0;
        if (g0_vld) begin
            grant[g0_idx] = 1'b1;
        end
        if (g1_vld) begin
            grant[g1_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Pointer moves one past the last round-robin grant. Port 1 is always
        // a round-robin grant and sits later in scan order than a round-robin
        // port 0; a forced port-0 grant on its own leaves the pointer alone.
        rr_ptr_d = rr_ptr_q;
        if (g1_vld) begin
            rr_ptr_d = wrap_inc(g1_idx);
        end else if (g0_vld && !forced) begin
            rr_ptr_d = wrap_inc(g0_idx);
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_valid[i] || grant[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != STARVE_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end

        conflict_cnt_d = conflict_cnt_q;
        if (skip_any && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end

        // Preg 0 is the hardwired zero register: the request is acknowledged
        // but never written.
        wren0_d  = g0_vld && (pdst_a[g0_idx] != '0);
        waddr0_d = g0_vld ? pdst_a[g0_idx] : '0;
        wdata0_d = g0_vld ? data_a[g0_idx] : '0;
        wren1_d  = g1_vld && (pdst_a[g1_idx] != '0);
        waddr1_d = g1_vld ? pdst_a[g1_idx] : '0;
        wdata1_d = g1_vld ? data_a[g1_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
            wren0_q        <= 1'b0;
            waddr0_q       <= '0;
            wdata0_q       <= '0;
            wren1_q        <= 1'b0;
            waddr1_q       <= '0;
            wdata1_q       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
            wren0_q        <= wren0_d;
            waddr0_q       <= waddr0_d;
            wdata0_q       <= wdata0_d;
            wren1_q        <= wren1_d;
            waddr1_q       <= waddr1_d;
            wdata1_q       <= wdata1_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign wren0        = wren0_q;
    assign waddr0       = waddr0_q;
    assign wdata0       = wdata0_q;
    assign wren1        = wren1_q;
    assign waddr1       = waddr1_q;
    assign wdata1       = wdata1_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_pregfile_wb_arbiter.sv
// Directed bench for pregfile_wb_arbiter: expected write-port values are queued when a request cycle is driven
// and compared one cycle later when the registered outputs appear.
// Grants are checked combinationally in the request cycle.

module tb_pregfile_wb_arbiter;

    localparam int NR = 4;
    localparam int PW = 6;
    localparam int DW = 64;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*PW-1:0]  req_pdst;
    logic [NR*DW-1:0]  req_data;
    logic              wren0;
    logic [PW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              wren1;
    logic [PW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic [31:0]       conflict_cnt;

    pregfile_wb_arbiter #(
        .NUM_REQ(NR), .PREG_W(PW), .DATA_W(DW), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pdst(req_pdst), .req_data(req_data),
        .wren0(wren0), .waddr0(waddr0), .wdata0(wdata0),
        .wren1(wren1), .waddr1(waddr1), .wdata1(wdata1),
        .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          wren0;
        logic [PW-1:0] waddr0;
        logic [DW-1:0] wdata0;
        logic          wren1;
        logic [PW-1:0] waddr1;
        logic [DW-1:0] wdata1;
    } exp_t;

    exp_t        sb [$];
    logic [PW-1:0] p_a [NR];
    logic [DW-1:0] d_a [NR];
    logic [31:0] data_seq;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [PW-1:0] p);
        data_seq       = data_seq + 32'd1;
        p_a[i]         = p;
        d_a[i]         = {16'hA5A5, 8'(i), 2'b00, p, data_seq};
        req_valid[i]   = 1'b1;
        req_pdst[i*PW +: PW] = p;
        req_data[i*DW +: DW] = d_a[i];
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    function automatic exp_t mk(input int g0, input int g1);
        exp_t e;
        e = '0;
        if (g0 >= 0 && p_a[g0] != '0) begin
            e.wren0  = 1'b1;
            e.waddr0 = p_a[g0];
            e.wdata0 = d_a[g0];
        end
        if (g1 >= 0 && p_a[g1] != '0) begin
            e.wren1  = 1'b1;
            e.waddr1 = p_a[g1];
            e.wdata1 = d_a[g1];
        end
        return e;
    endfunction

    // Called just after a falling edge with the request inputs in place.
    // g0/g1 are the requester indices expected on port 0/1, -1 for none.
    task automatic do_cycle(input int g0, input int g1, input string tag);
        exp_t        e;
        logic [NR-1:0] er;
        #1;
        er = '0;
        if (g0 >= 0) er[g0] = 1'b1;
        if (g1 >= 0) er[g1] = 1'b1;
        chk({tag, ":ready"}, 64'(req_ready), 64'(er));
        sb.push_back(mk(g0, g1));
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ":wren0"}, 64'(wren0), 64'(e.wren0));
        chk({tag, ":wren1"}, 64'(wren1), 64'(e.wren1));
        if (e.wren0) begin
            chk({tag, ":waddr0"}, 64'(waddr0), 64'(e.waddr0));
            chk({tag, ":wdata0"}, wdata0, e.wdata0);
        end
        if (e.wren1) begin
            chk({tag, ":waddr1"}, 64'(waddr1), 64'(e.waddr1));
            chk({tag, ":wdata1"}, wdata1, e.wdata1);
        end
        @(negedge clock);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        n_fail    = 0;
        data_seq  = 32'd0;
        req_valid = '0;
        req_pdst  = '0;
        req_data  = '0;
        reset     = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, PW'(i + 1));
        @(negedge clock);

        // Reset held with every requester valid: nothing granted, outputs clear.
        do_cycle(-1, -1, "rst_a");
        do_cycle(-1, -1, "rst_b");
        reset = 1'b0;
        for (int i = 0; i < NR; i++) drop(i);
        do_cycle(-1, -1, "post_rst");
        chk("post_rst:conflict_cnt", 64'(conflict_cnt), 64'd0);

        // All four valid with distinct pdsts: pairs rotate {0,1},{2,3},{0,1}.
        for (int i = 0; i < NR; i++) set_req(i, PW'(5 + i));
        do_cycle(0, 1, "rr_a");
        set_req(0, 6'd5); set_req(1, 6'd6);
        do_cycle(2, 3, "rr_b");
        set_req(2, 6'd7); set_req(3, 6'd8);
        do_cycle(0, 1, "rr_c");
        for (int i = 0; i < NR; i++) drop(i);
        do_cycle(-1, -1, "rr_idle");

        // Lone pdst-0 request: acknowledged, never written. Pointer lands on 0.
        set_req(3, 6'd0);
        d_a[3] = 64'hDEAD;
        req_data[3*DW +: DW] = 64'hDEAD;
        do_cycle(3, -1, "pdst0");
        drop(3);

        // Same-pdst deferral: req1 skipped for port 1, req2 takes it.
        set_req(0, 6'd9); set_req(1, 6'd9); set_req(2, 6'd12);
        do_cycle(0, 2, "conf_a");
        chk("conf_a:conflict_cnt", 64'(conflict_cnt), 64'd1);
        drop(0); drop(2);
        do_cycle(1, -1, "conf_b");
        drop(1);

        // Move the pointer to 1 with a lone grant to req0.
        set_req(0, 6'd15);
        do_cycle(0, -1, "ptr1");

        // Starvation: req1 (pdst 30) wins port 0 each cycle, req2 (pdst 30)
        // is deferred, req0 wraps onto port 1 and keeps the pointer at 1.
        set_req(0, 6'd17); set_req(1, 6'd30); set_req(2, 6'd30);
        for (int k = 0; k < 4; k++) begin
            do_cycle(1, 0, $sformatf("starve_wait%0d", k));
            set_req(0, PW'(18 + k));
            set_req(1, 6'd30);
        end
        do_cycle(2, 0, "starve_force");
        chk("starve:conflict_cnt", 64'(conflict_cnt), 64'd6);
        drop(0); drop(2);
        do_cycle(1, -1, "starve_after");
        drop(1);

        // Grant to pdst 20, then reset while req2 is presented again.
        set_req(2, 6'd20);
        do_cycle(2, -1, "pre_rst");
        set_req(2, 6'd20);
        reset = 1'b1;
        do_cycle(-1, -1, "rst_mid");
        reset = 1'b0;
        chk("rst_mid:conflict_cnt", 64'(conflict_cnt), 64'd0);
        // Pointer must be back at 0 (it was 3 before reset).
        for (int i = 0; i < NR; i++) set_req(i, PW'(21 + i));
        do_cycle(0, 1, "rst_ptr");
        for (int i = 0; i < NR; i++) drop(i);
        do_cycle(-1, -1, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
